// File: rtl/cpu_mem_bus_unit.sv
// cpu_mem_bus_unit: memory-stage access controller. BRAM stores complete in
// the request cycle; BRAM loads and all accelerator-bus accesses stall the
// pipeline until a DONE cycle, which is also where load data is written back.
// Bus waits are bounded, and a timeout raises a sticky error flag.
module cpu_mem_bus_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                N_CH     = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] BUS_BASE = ADDR_W'(16'hF000),
  parameter int                TIMEOUT  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [3:0]               req_dest,
  output logic                     stall,
  output logic                     wb_valid,
  output logic [3:0]               wb_dest,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [N_CH-1:0]          bus_tx_valid,
  output logic [DATA_W-1:0]        bus_tx_data,
  input  logic [N_CH-1:0]          bus_tx_ready,
  input  logic [N_CH-1:0]          bus_rx_valid,
  input  logic [N_CH*DATA_W-1:0]   bus_rx_data,
  output logic [N_CH-1:0]          bus_rx_ready,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + MEM_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_BUS_WR, S_BUS_RD, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [3:0]         dest_q, dest_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               wb_valid_q, wb_valid_d;
  logic               err_q, err_d;

  logic               is_bus;
  logic [CHW-1:0]     ch_sel;
  logic [N_CH-1:0]    ch_onehot;
  logic               tx_hs, rx_hs, time_up;
  logic [DATA_W-1:0]  rx_slice;

  assign is_bus    = (req_addr >= BUS_BASE);
  // A single channel has no select bits; pin it to channel 0.
  assign ch_sel    = (N_CH > 1) ? req_addr[CHW-1:0] : '0;
  assign ch_onehot = N_CH'(1) << ch_q;
  assign tx_hs     = bus_tx_ready[ch_q];
  assign rx_hs     = bus_rx_valid[ch_q];
  assign rx_slice  = bus_rx_data[int'(ch_q)*DATA_W +: DATA_W];
  // Last permitted wait cycle: the counter starts at 0 on state entry.
  assign time_up   = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and datapath capture for the access FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    dest_d     = dest_q;
    tx_data_d  = tx_data_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    // A timeout set below overrides this clear.
    err_d      = err_q & ~err_clr;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!is_bus) begin
            // BRAM stores finish this cycle; only loads leave IDLE.
            if (!req_write) begin
              dest_d  = req_dest;
              cnt_d   = CNT_W'(MEM_LAT);
              state_d = S_MEM_RD;
            end
          end else begin
            ch_d  = ch_sel;
            cnt_d = '0;
            if (req_write) begin
              tx_data_d = req_wdata;
              state_d   = S_BUS_WR;
            end else begin
              dest_d  = req_dest;
              state_d = S_BUS_RD;
            end
          end
        end
      end
      S_MEM_RD: begin
        if (cnt_q == CNT_W'(1)) begin
          wb_data_d  = mem_rdata;
          wb_valid_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BUS_WR: begin
        if (tx_hs) begin
          state_d = S_DONE;
        end else if (time_up) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BUS_RD: begin
        if (rx_hs) begin
          wb_data_d  = rx_slice;
          wb_valid_d = 1'b1;
          state_d    = S_DONE;
        end else if (time_up) begin
          // A dead channel still retires the load, with all-ones data.
          wb_data_d  = '1;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Request inputs still show the completing instruction; ignore them.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any access in flight without writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      dest_q     <= '0;
      tx_data_q  <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      dest_q     <= dest_d;
      tx_data_q  <= tx_data_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  // Request-cycle decode is combinational, so it is gated by rst to keep
  // every output low while reset is held.
  assign stall = ~rst & (
                   ((state_q == S_IDLE) & req_valid & (is_bus | ~req_write)) |
                   (state_q == S_MEM_RD) | (state_q == S_BUS_WR) |
                   (state_q == S_BUS_RD));
  assign mem_en       = ~rst & (state_q == S_IDLE) & req_valid & ~is_bus;
  assign mem_wr       = mem_en & req_write;
  assign mem_addr     = req_addr;
  assign mem_wdata    = req_wdata;
  assign bus_tx_valid = (state_q == S_BUS_WR) ? ch_onehot : '0;
  assign bus_rx_ready = (state_q == S_BUS_RD) ? ch_onehot : '0;
  assign bus_tx_data  = tx_data_q;
  assign wb_valid     = wb_valid_q;
  assign wb_dest      = dest_q;
  assign wb_data      = wb_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_cpu_mem_bus_unit.sv
// tb_cpu_mem_bus_unit: directed and randomized accesses checked cycle by
// cycle against timing rules and a reference memory kept in the bench.
module tb_cpu_mem_bus_unit;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int NCH = 4;
  localparam int LAT = 2;
  localparam int TO  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic [3:0]        req_dest;
  logic              stall, wb_valid;
  logic [3:0]        wb_dest;
  logic [DW-1:0]     wb_data;
  logic              mem_en, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [NCH-1:0]    bus_tx_valid, bus_tx_ready, bus_rx_valid, bus_rx_ready;
  logic [DW-1:0]     bus_tx_data;
  logic [NCH*DW-1:0] bus_rx_data;
  logic              err, err_clr;

  always #5 clk = ~clk;

  cpu_mem_bus_unit #(
    .DATA_W(DW), .ADDR_W(AW), .N_CH(NCH), .MEM_LAT(LAT),
    .BUS_BASE(16'hF000), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dest(req_dest),
    .stall(stall), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bus_tx_valid(bus_tx_valid), .bus_tx_data(bus_tx_data),
    .bus_tx_ready(bus_tx_ready), .bus_rx_valid(bus_rx_valid),
    .bus_rx_data(bus_rx_data), .bus_rx_ready(bus_rx_ready),
    .err(err), .err_clr(err_clr)
  );

  // BRAM environment with LAT-cycle registered read.
  logic [DW-1:0] bram    [256];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_wr) bram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en) rd_pipe[0] <= bram[mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  logic [7:0]    written [$];
  bit            exp_err;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_dest"}, wb_dest, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_wr"}, mem_wr, 0);
    chk({tag, "_tx_valid"}, bus_tx_valid, 0);
    chk({tag, "_tx_data"}, bus_tx_data, 0);
    chk({tag, "_rx_ready"}, bus_rx_ready, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One complete access. d = wait cycles before the target channel
  // handshakes (d >= TO means it never does); clr holds err_clr while waiting.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [3:0] dest, input int d, input logic [15:0] rxd,
                        input bit clr);
    bit         bus, tmo;
    int         ch;
    logic [3:0] oh;
    bus = (addr >= 16'hF000);
    ch  = int'(addr[1:0]);
    oh  = 4'b0001 << ch;
    cyc();
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd;   req_dest  = dest;
    // Every non-target channel is active, so any mis-selection shows up.
    bus_tx_ready = ~oh;
    bus_rx_valid = ~oh;
    bus_rx_data  = {$urandom, $urandom};
    if (bus && !wr) bus_rx_data[ch*16 +: 16] = rxd;
    #1;
    chk("req_wb_valid", wb_valid, 0);
    chk("req_stall", stall, bus || !wr);
    chk("req_mem_en", mem_en, !bus);
    chk("req_mem_wr", mem_wr, !bus && wr);
    chk("req_mem_addr", mem_addr, addr);
    if (!bus && wr) begin
      ref_mem[addr[7:0]] = wd;
      written.push_back(addr[7:0]);
      return;
    end
    if (!bus) begin
      for (int i = 0; i < LAT; i++) begin
        cyc();
        #1;
        chk("rd_stall", stall, 1);
        chk("rd_wb_valid", wb_valid, 0);
      end
      cyc();
      #1;
      chk("rd_done_stall", stall, 0);
      chk("rd_done_wb_valid", wb_valid, 1);
      chk("rd_done_wb_dest", wb_dest, dest);
      chk("rd_done_wb_data", wb_data, ref_mem[addr[7:0]]);
      return;
    end
    tmo = 1'b0;
    for (int w = 0; w < TO; w++) begin
      cyc();
      err_clr = clr;
      if (w >= d) begin
        bus_tx_ready = 4'hF;
        bus_rx_valid = 4'hF;
      end
      #1;
      chk("wait_stall", stall, 1);
      chk("wait_tx_valid", bus_tx_valid, wr ? oh : 4'h0);
      chk("wait_rx_ready", bus_rx_ready, wr ? 4'h0 : oh);
      chk("wait_wb_valid", wb_valid, 0);
      if (wr) chk("wait_tx_data", bus_tx_data, wd);
      if (w >= d) break;
      if (w == TO - 1) tmo = 1'b1;
    end
    cyc();
    err_clr = 1'b0;
    bus_tx_ready = '0;
    bus_rx_valid = '0;
    #1;
    if (tmo) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    chk("done_stall", stall, 0);
    chk("done_tx_valid", bus_tx_valid, 0);
    chk("done_rx_ready", bus_rx_ready, 0);
    chk("done_wb_valid", wb_valid, !wr);
    chk("done_err", err, exp_err);
    if (!wr) begin
      chk("done_wb_data", wb_data, tmo ? 16'hFFFF : rxd);
      chk("done_wb_dest", wb_dest, dest);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, d;
    logic [15:0] a;
    exp_err = 1'b0;
    rst = 1'b1; err_clr = 1'b0;
    bus_tx_ready = '0; bus_rx_valid = '0; bus_rx_data = '0;
    // A load request held during reset must not leak out.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020;
    req_wdata = 16'hA5A5; req_dest = 4'd3;
    #12;
    chk_zero("reset");
    chk("reset_mem_addr", mem_addr, 16'h0020);
    chk("reset_mem_wdata", mem_wdata, 16'hA5A5);
    cyc();
    rst = 1'b0; req_valid = 1'b0;

    // BRAM store then load back into r5.
    access(1'b1, 16'h0010, 16'h1234, 4'd0, 0, 16'h0, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 4'd5, 0, 16'h0, 1'b0);
    // Bus store on channel 3, ready low 5 cycles, accepted on last wait cycle.
    access(1'b1, 16'hF003, 16'hC0DE, 4'd0, 5, 16'h0, 1'b0);
    // Bus load from channel 1 while channel 0 also offers data.
    access(1'b0, 16'hF001, 16'h0000, 4'd7, 2, 16'hBEEF, 1'b0);
    // Bus load that never handshakes.
    access(1'b0, 16'hF002, 16'h0000, 4'd2, 100, 16'h0, 1'b0);
    // err_clr alone clears on the next cycle.
    cyc();
    req_valid = 1'b0; err_clr = 1'b1;
    #1;
    chk("clr_err_hold", err, 1);
    cyc();
    err_clr = 1'b0; exp_err = 1'b0;
    #1;
    chk("clr_err_cleared", err, 0);
    // err_clr held across a timing-out store: set wins.
    access(1'b1, 16'hF000, 16'h5555, 4'd0, 100, 16'h0, 1'b1);
    cyc();
    req_valid = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; exp_err = 1'b0;
    #1;
    chk("clr_err_again", err, 0);

    // Randomized mix, mostly back-to-back.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 1 && written.size() == 0) kind = 0;
      case (kind)
        0: access(1'b1, {8'h00, 8'($urandom)}, 16'($urandom), 4'd0, 0, 16'h0, 1'b0);
        1: access(1'b0, {8'h00, written[$urandom_range(0, written.size() - 1)]},
                  16'h0, 4'($urandom), 0, 16'h0, 1'b0);
        default: begin
          a = 16'hF000 + 16'($urandom_range(0, 16'h0FFF));
          d = $urandom_range(0, TO + 1);
          access(kind == 2, a, 16'($urandom), 4'($urandom), d, 16'($urandom),
                 $urandom_range(0, 7) == 0);
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        cyc();
        req_valid = 1'b0;
        #1;
        chk("gap_stall", stall, 0);
        chk("gap_wb_valid", wb_valid, 0);
      end
    end

    // Make err set so reset visibly clears it.
    access(1'b0, 16'hF001, 16'h0000, 4'd1, 100, 16'h0, 1'b0);
    // Reset in the middle of a channel-2 bus load.
    cyc();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hF002; req_dest = 4'd9;
    bus_rx_valid = '0; bus_tx_ready = '0;
    cyc();
    #1;
    chk("mid_rx_ready", bus_rx_ready, 4'b0100);
    cyc();
    rst = 1'b1;
    #1;
    chk_zero("mid_reset");
    cyc();
    rst = 1'b0; req_valid = 1'b0; bus_rx_valid = 4'hF; exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("post_reset_wb_valid", wb_valid, 0);
      chk("post_reset_stall", stall, 0);
      chk("post_reset_err", err, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
